// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-2 shift-add multiplier.
// Used by mul_radix2 and mul_sign_fix.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Magnitude of an operand; the most negative value maps onto its unsigned twin.
  function automatic logic [MUL_WIDTH-1:0] mul_abs(input logic [MUL_WIDTH-1:0] x,
                                                    input logic             sgn);
    return (sgn && x[MUL_WIDTH-1]) ? (~x + MUL_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// Used for operand magnitudes and the final product sign correction.
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int W = MUL_WIDTH
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_radix2.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU with a pipeline stall.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mul_radix2
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               valid,
  input  logic               sign,
  input  logic               cancel,
  output logic               mul_stall,
  output logic [2*WIDTH-1:0] result
);

  mul_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic                 last_iter;

  mul_sign_fix #(.W(WIDTH)) u_abs_a (
    .x   (a),
    .neg (sign & a[WIDTH-1]),
    .y   (a_abs)
  );

  mul_sign_fix #(.W(WIDTH)) u_abs_b (
    .x   (b),
    .neg (sign & b[WIDTH-1]),
    .y   (b_abs)
  );

  // Accumulator value after this cycle's partial product; carry out is dropped.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  mul_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .x   (acc_d),
    .neg (neg_q),
    .y   (prod_fixed)
  );

`ifdef MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero: no further partial products can be added.
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1));
`endif

  assign mul_stall = ~cancel & (((state_q == IDLE) & valid) | (state_q == BUSY));
  assign result    = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (cancel) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_abs};
            mplier_q <= b_abs;
            acc_q    <= '0;
            neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_q <= prod_fixed;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_radix2.sv
// Self-checking bench for mul_radix2: vector table, corner sequences, random vs. arithmetic model.
// Latency expectations follow MUL_EARLY_TERM_EN when it is defined.
module tb_mul_radix2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        valid = 1'b0;
  logic        sign = 1'b0;
  logic        cancel = 1'b0;
  logic        mul_stall;
  logic [63:0] result;

  int n_pass = 0;
  int n_total = 0;

  mul_radix2 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .sign      (sign),
    .cancel    (cancel),
    .mul_stall (mul_stall),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference product: plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    longint px, py;
    if (s) begin
      px = $signed(x);
      py = $signed(y);
    end else begin
      px = {32'd0, x};
      py = {32'd0, y};
    end
    return px * py;
  endfunction

  // Number of clock edges from accept until DONE is reached.
  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int idx;
    m = (s && y[31]) ? (32'd0 - y) : y;
    idx = 0;
    for (int i = 0; i < 32; i++) if (m[i]) idx = i;
    return 2 + idx;
`else
    return 33 + 0 * int'({x[0], y[0], s});
`endif
  endfunction

  // One request; inputs scrambled after accept to prove the operands were latched.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output logic [63:0] res, output int cyc, output logic [63:0] res_hold);
    @(negedge clk);
    a = x; b = y; sign = s; valid = 1'b1;
    cyc = 0;
    #1;
    while (mul_stall && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        valid = 1'b0;
        a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
      end
    end
    valid = 1'b0;
    res = result;
    @(posedge clk); #1;
    res_hold = result;
  endtask

  initial begin
    logic [63:0] r, rh, prev;
    logic [31:0] x, y, x2, y2;
    logic        s, s2;
    int          c;

    vec[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vec[1] = '{32'hFFFF_FFF9, 32'd6,         1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
    vec[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    vec[3] = '{32'd0,         32'd123,       1'b1, 64'h0};
    vec[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1};
    vec[5] = '{32'd123,       32'd0,         1'b1, 64'h0};
    vec[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000};
    vec[7] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vec[8] = '{32'd3,         32'd1,         1'b0, 64'd3};
    vec[9] = '{32'd0,         32'hFFFF_FFFF, 1'b1, 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_result", result, 64'h0);
    check("reset_stall", 64'(mul_stall), 64'h0);

    for (int i = 0; i < 10; i++) begin
      run_op(vec[i].a, vec[i].b, vec[i].s, r, c, rh);
      $display("txn vec%0d a=%h b=%h s=%0d result=%h cycles=%0d", i, vec[i].a, vec[i].b,
               vec[i].s, r, c);
      check("vec_result", r, vec[i].exp);
      check("vec_latency", 64'(c), 64'(ref_lat(vec[i].a, vec[i].b, vec[i].s)));
      check("vec_hold", rh, vec[i].exp);
    end

    // Cancel during BUSY: previous product must survive, FSM back to IDLE.
    run_op(32'd5, 32'd7, 1'b0, prev, c, rh);
    @(negedge clk);
    a = 32'h1234; b = 32'h8000_0001; sign = 1'b0; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cancel_pre_stall", 64'(mul_stall), 64'h1);
    cancel = 1'b1;
    #1;
    check("cancel_stall", 64'(mul_stall), 64'h0);
    @(posedge clk); #1; cancel = 1'b0;
    #1;
    check("cancel_idle_stall", 64'(mul_stall), 64'h0);
    check("cancel_result", result, prev);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_no_late_write", result, prev);
    $display("txn cancel_busy result=%h", result);

    // Cancel wins over valid in IDLE.
    @(negedge clk);
    a = 32'd9; b = 32'd9; valid = 1'b1; cancel = 1'b1;
    #1;
    check("cancel_valid_stall", 64'(mul_stall), 64'h0);
    @(posedge clk); #1; valid = 1'b0; cancel = 1'b0;
    #1;
    check("cancel_valid_not_accepted", 64'(mul_stall), 64'h0);
    $display("txn cancel_idle stall=%0d", mul_stall);

    // Reset mid-operation.
    @(negedge clk);
    a = 32'h0BAD_F00D; b = 32'hF000_0003; sign = 1'b0; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    #1;
    check("rst_busy_result", result, 64'h0);
    check("rst_busy_stall", 64'(mul_stall), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    check("rst_busy_no_late_write", result, 64'h0);
    $display("txn rst_busy result=%h", result);

    // Back-to-back: valid held through DONE is a fresh request in the following IDLE cycle.
    x = 32'hFFFF_FFF9; y = 32'h0001_0003; s = 1'b1;
    x2 = 32'hDEAD_BEEF; y2 = 32'h0000_0F0F; s2 = 1'b0;
    @(negedge clk);
    a = x; b = y; sign = s; valid = 1'b1;
    c = 0;
    #1;
    while (mul_stall && c < 200) begin
      @(posedge clk); #1; c++;
      if (c == 1) begin a = x2; b = y2; sign = s2; end
    end
    check("b2b_first_result", result, ref_prod(x, y, s));
    check("b2b_first_latency", 64'(c), 64'(ref_lat(x, y, s)));
    @(posedge clk); #1;
    check("b2b_accept_stall", 64'(mul_stall), 64'h1);
    c = 0;
    while (mul_stall && c < 200) begin
      @(posedge clk); #1; c++;
      if (c == 1) valid = 1'b0;
    end
    valid = 1'b0;
    check("b2b_second_result", result, ref_prod(x2, y2, s2));
    check("b2b_second_latency", 64'(c), 64'(ref_lat(x2, y2, s2)));
    $display("txn b2b result=%h cycles=%0d", result, c);
    @(posedge clk);

    // Random operands, with boundary values mixed in.
    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = $urandom_range(0, 255); y = $urandom_range(0, 255); end
        2: begin x = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF; y = $urandom; end
        default: begin x = $urandom; y = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'h8000_0000; end
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(x, y, s, r, c, rh);
      $display("txn rnd%0d a=%h b=%h s=%0d result=%h cycles=%0d", i, x, y, s, r, c);
      check("rnd_result", r, ref_prod(x, y, s));
      check("rnd_latency", 64'(c), 64'(ref_lat(x, y, s)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
